// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: BCD digit geometry, the
// measurement FSM state encoding and the default digit count. Also used
// by the display decoder, so keep it free of block-specific logic.
package freq_meter_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam int DEFAULT_DIGITS = 4;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    COUNT      = 1'b1
  } gate_state_t;

endpackage

// File: rtl/freq_gate_counter_bcd_digit.sv
// bcd_digit: one decade (0..9) of the BCD event counter.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   en         : increment request arriving along the carry chain
//   hold       : suppresses the increment (counter saturation)
//   clr        : synchronous clear to 0 (highest priority)
//   preset     : synchronous load of 1
//   q          : current digit value
//   carry      : high when this digit is asked to step past 9
module bcd_digit
  import freq_meter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               hold,
  input  logic               clr,
  input  logic               preset,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  // Carry depends only on the request, not on hold, so the top digit's
  // carry can be used to detect (and then block) a saturating increment
  // without a combinational loop.
  assign carry = en && (q == DIGIT_MAX);

  // Digit register: clear beats preset beats increment; 9 rolls to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (preset) begin
      q <= DIGIT_W'(1);
    end else if (en && !hold) begin
      q <= (q == DIGIT_MAX) ? '0 : q + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts rising edges of sig_in over one period of the
// selected gate clock and publishes the count as packed BCD.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   gate_ref   : selected gate clock (async, 0 when no range selected)
//   sig_in     : signal under measurement (async)
//   range_chg  : one-cycle pulse, abandons the window in progress
//   bcd_out    : last published count, digit 0 in [3:0]
//   ovf        : last published count was saturated
//   valid      : one-cycle strobe when bcd_out/ovf update
//   busy       : a counting window is open
module freq_gate_counter
  import freq_meter_pkg::*;
#(
  parameter int DIGITS      = DEFAULT_DIGITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      gate_ref,
  input  logic                      sig_in,
  input  logic                      range_chg,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      ovf,
  output logic                      valid,
  output logic                      busy
);

  logic [1:0] async_in;
  logic [1:0] edge_rise;
  logic       gate_rise;
  logic       sig_rise;

  assign async_in  = {sig_in, gate_ref};
  assign gate_rise = edge_rise[0];
  assign sig_rise  = edge_rise[1];

  // Identical synchronizer + registered edge detector for both inputs so
  // gate and signal edges see the same latency and windows stay aligned.
  for (genvar i = 0; i < 2; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q    <= '0;
        sync_prev <= 1'b0;
        rise_q    <= 1'b0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in[i]};
        sync_prev <= sync_q[SYNC_STAGES-1];
        rise_q    <= sync_q[SYNC_STAGES-1] && !sync_prev;
      end
    end

    assign edge_rise[i] = rise_q;
  end

  gate_state_t                state;
  logic                       cnt_ovf;
  logic                       window_start;
  logic                       cnt_clr;
  logic                       cnt_preset;
  logic                       count_req;
  logic                       sat_hit;
  logic [DIGITS-1:0]          digit_carry;
  logic [DIGIT_W*DIGITS-1:0]  count;

  // A gate edge opens a fresh window unless a range change kills it.
  // A signal edge coincident with the gate edge belongs to the new window,
  // hence the preset to 1 instead of a clear.
  assign window_start = gate_rise && !range_chg;
  assign cnt_clr      = range_chg || (state == WAIT_FIRST) || window_start;
  assign cnt_preset   = window_start && sig_rise;
  assign count_req    = (state == COUNT) && sig_rise && !cnt_clr;
  assign sat_hit      = digit_carry[DIGITS-1];

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic en_d;
    logic clr_d;
    logic preset_d;

    if (d == 0) begin : g_lsd
      assign en_d     = count_req;
      assign clr_d    = cnt_clr && !cnt_preset;
      assign preset_d = cnt_preset;
    end else begin : g_upper
      assign en_d     = digit_carry[d-1];
      assign clr_d    = cnt_clr;
      assign preset_d = 1'b0;
    end

    bcd_digit u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en_d),
      .hold   (sat_hit),
      .clr    (clr_d),
      .preset (preset_d),
      .q      (count[DIGIT_W*d +: DIGIT_W]),
      .carry  (digit_carry[d])
    );
  end

  // Sticky overflow for the current window: set when an increment is
  // attempted at all-9s, cleared together with the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ovf <= 1'b0;
    end else if (cnt_clr) begin
      cnt_ovf <= 1'b0;
    end else if (sat_hit) begin
      cnt_ovf <= 1'b1;
    end
  end

  // Measurement FSM with registered outputs. range_chg has priority over
  // a coincident gate edge; a gate edge in COUNT publishes the count that
  // excludes the signal edge arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_FIRST;
      bcd_out <= '0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (range_chg) begin
        state <= WAIT_FIRST;
        busy  <= 1'b0;
      end else if (gate_rise) begin
        case (state)
          WAIT_FIRST: begin
            state <= COUNT;
            busy  <= 1'b1;
          end
          COUNT: begin
            bcd_out <= count;
            ovf     <= cnt_ovf;
            valid   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/freq_gate_counter.md
# freq_gate_counter

Measurement core of the frequency meter, directly downstream of the gate-clock selector. It takes the selected gate clock (10 Hz / 100 Hz / 1 kHz) and the unknown input signal, both asynchronous to the system clock. It counts rising edges of the input over exactly one gate period and publishes the count as packed BCD to the display stage, with a one-cycle valid strobe and an overflow flag.

## Interface
- DIGITS, 4, number of BCD digits in the count and on the output
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2)
- clk  in  1  system clock; the only clock in the block
- rst_n  in  1  asynchronous active-low reset
- gate_ref  in  1  selected gate clock from the selector; async; constant 0 when no range is selected
- sig_in  in  1  signal under measurement; async
- range_chg  in  1  one-cycle pulse when the range selection changes; discards the window in progress
- bcd_out  out  4*DIGITS  last published count; digit 0 in [3:0]
- ovf  out  1  last published count saturated
- valid  out  1  one-cycle strobe, high in the cycle bcd_out/ovf update
- busy  out  1  high while a counting window is open (state COUNT)

## Operation
- Both gate_ref and sig_in pass through SYNC_STAGES-FF synchronizers and a rising-edge detector, giving gate_rise and sig_rise: one-cycle pulses in the clk domain.
- FSM has two states:
  - WAIT_FIRST (reset state): ignores sig_rise, counter held at 0. On gate_rise: go to COUNT, clear the counter, and publish nothing. This discards the partial first window.
  - COUNT: each sig_rise increments the DIGITS-digit BCD counter.
- gate_rise in COUNT:
  - Load the counter value into bcd_out and the overflow bit into ovf; valid = 1 next cycle.
  - Restart the counter at 1 if sig_rise is in the same cycle, else at 0. A coincident edge belongs to the new window. Stay in COUNT.
- BCD arithmetic: each digit counts 0–9 and carries into the next. Digit 0 rolls 9→0 with carry. There is no binary-to-BCD conversion.
- Saturation: an increment from all-9s (9999 for DIGITS=4) does not wrap. The counter holds all-9s and sets the internal ovf bit. The ovf bit clears with the counter at the start of each window.
- range_chg in any state: return to WAIT_FIRST and clear the counter; outputs hold. range_chg wins over a coincident gate_rise: no publish occurs.
- gate_ref stuck at 0: no window closes. Outputs hold the last result indefinitely and busy stays as it is.
- Reset values: bcd_out = 0, ovf = 0, valid = 0, busy = 0, state WAIT_FIRST, synchronizers all 0.
- Reset asserted mid-window: everything clears immediately (asynchronously) and the partial count is lost. After release, the first gate_rise only opens a window.

## Timing
- Input pin edge to gate_rise / sig_rise: SYNC_STAGES+1 clk cycles. gate_ref and sig_in share the same latency, so window alignment is preserved.
- gate_rise in cycle k → bcd_out, ovf, valid updated and visible in cycle k+1; valid low in k+2.
- busy rises in the cycle after the first gate_rise and falls in the cycle after range_chg.
- Maximum countable sig_in frequency is below clk/2. Edge loss above that rate is not detected.
- Window resolution is ±1 count, from synchronizer phase.

## Structure
- freq_meter_pkg holds:
  - the BCD digit width (4) and the digit maximum (4'd9)
  - the FSM state encodings WAIT_FIRST and COUNT
  - the default DIGITS value
- The package is shared with the display decoder.
- Sub-module bcd_digit: one decade digit with enable, synchronous clear, preset-to-1 and carry-out. It is instantiated DIGITS times in a carry chain.
- The synchronizer and edge detector are inline, one instance per input (generate).

## Test plan
- Reset, then gate_ref period 200 clk, sig_in period 8 clk: first gate edge gives no valid. Each later window gives valid with bcd_out = 16'h0025.
- sig_in period 2 clk, gate period 40 000 clk: count exceeds 9999 → bcd_out = 16'h9999, ovf = 1. The next window with sig period 20 gives 16'h2000, ovf = 0.
- Align a sig_in edge to a gate_ref edge (same clk) with sig period 10, gate 100: each published value = 16'h0010. The coincident edge is counted in the new window, with no double count or loss.
- range_chg pulse in the same cycle as gate_rise: no valid, busy drops, bcd_out holds the previous value. The next gate_rise publishes nothing. The following one publishes normally.
- Assert rst_n low mid-window for 3 cycles: all outputs 0 immediately. After release, the first valid appears only after the second gate_rise.
- gate_ref held 0 for 10 000 cycles with sig_in toggling: no valid, bcd_out unchanged.
